// File: rtl/lc3b_types.sv
// Shared LC-3b types for the L2/pmem path: line, word, beat and adaptor FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [31:0]  lc3b_pmem_beat;

  localparam int PMEM_BEATS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RESP     = 2'd3
  } l2_state_e;

endpackage

// File: rtl/l2_burst_adaptor.sv
// Converts a single-cycle-handshake L1 line request into a 4 x 32-bit pmem burst.
// FSM and beat datapath live together; all outputs are decoded from registered state.
module l2_burst_adaptor
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          l2_read,
  input  logic          l2_write,
  input  lc3b_word      l2_address,
  input  lc3b_cacheline l2_wdata,
  output logic          l2_resp,
  output lc3b_cacheline l2_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_pmem_beat pmem_wdata,
  input  lc3b_pmem_beat pmem_rdata,
  input  logic          pmem_resp
);

  localparam logic [1:0] LAST_BEAT = 2'(PMEM_BEATS_PER_LINE - 1);

  l2_state_e     state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  lc3b_word      addr_q, addr_d;
  lc3b_cacheline wline_q, wline_d;
  lc3b_cacheline rline_q, rline_d;

  // Beat n sits at line bits [32n+31:32n]; {n,5'b0} is 32*n.
  logic [6:0] beat_lsb;
  assign beat_lsb = {cnt_q, 5'd0};

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next-state and beat bookkeeping; request inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        // Write wins so a dirty eviction goes out before the refill.
        if (l2_write) begin
          state_d = WR_BURST;
          addr_d  = l2_address & 16'hFFF0;
          wline_d = l2_wdata;
          cnt_d   = 2'd0;
        end else if (l2_read) begin
          state_d = RD_BURST;
          addr_d  = l2_address & 16'hFFF0;
          cnt_d   = 2'd0;
        end
      end
      RD_BURST: begin
        if (pmem_resp) begin
          rline_d[beat_lsb +: 32] = pmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WR_BURST: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pmem_read    = (state_q == RD_BURST);
  assign pmem_write   = (state_q == WR_BURST);
  assign l2_resp      = (state_q == RESP);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wline_q[beat_lsb +: 32];
  assign l2_rdata     = rline_q;

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Self-checking bench: bench-side pmem responder with random stalls; expected lines,
// addresses and latencies come from the line/burst rules, not from DUT state.
module tb_l2_burst_adaptor;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          l2_read, l2_write;
  lc3b_word      l2_address;
  lc3b_cacheline l2_wdata;
  logic          l2_resp;
  lc3b_cacheline l2_rdata;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address;
  lc3b_pmem_beat pmem_wdata;
  lc3b_pmem_beat pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_rdata = '0;

  always #5 clk = ~clk;

  l2_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // One L1 transaction. Cycle 0 is the IDLE cycle in which the request is presented.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] addr,
                         input logic [127:0] line, input bit use_pat, input logic [7:0] pat,
                         input bit use_fix, input logic [127:0] fix, input bit scramble,
                         input string name);
    logic [127:0] got_line = '0;
    logic [15:0]  exp_addr = {addr[15:4], 4'h0};
    logic [31:0]  d;
    int beat = 0, stalls = 0;
    bit done = 0, r;
    @(negedge clk);
    l2_write = wr; l2_read = rd; l2_address = addr; l2_wdata = line; pmem_resp = 0;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || l2_resp !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: rd=%b wr=%b resp=%b required 0 0 0", name, pmem_read, pmem_write, l2_resp);
    end
    for (int c = 1; c < 200 && !done; c++) begin
      @(negedge clk);
      if (l2_resp === 1'b1) begin
        done = 1;
        pmem_resp = 0;
        checks++;
        if (c != 5 + stalls) begin
          errors++;
          $display("FAIL %s latency: l2_resp in cycle %0d required %0d", name, c, 5 + stalls);
        end
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
          errors++;
          $display("FAIL %s resp_flags: rd=%b wr=%b required 0 0", name, pmem_read, pmem_write);
        end
        if (!wr) exp_rdata = got_line;
        checks++;
        if (l2_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h required %h", name, l2_rdata, exp_rdata);
        end
      end else begin
        checks++;
        if (pmem_write !== wr || pmem_read !== !wr) begin
          errors++;
          $display("FAIL %s burst_flags cyc%0d: rd=%b wr=%b required %b %b",
                   name, c, pmem_read, pmem_write, !wr, wr);
        end
        checks++;
        if (pmem_address !== exp_addr) begin
          errors++;
          $display("FAIL %s address cyc%0d: got %h required %h", name, c, pmem_address, exp_addr);
        end
        if (wr) begin
          checks++;
          if (l2_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s rdata_during_write: got %h required %h", name, l2_rdata, exp_rdata);
          end
        end
        r = use_pat ? pat[(c - 1) & 7] : ($urandom_range(0, 99) < 65);
        if (r && beat >= 4) begin
          checks++; errors++;
          $display("FAIL %s overrun: beat %0d acked without l2_resp, required at most 4", name, beat + 1);
          done = 1; r = 0;
        end
        if (r) begin
          if (wr) begin
            checks++;
            if (pmem_wdata !== line[32*beat +: 32]) begin
              errors++;
              $display("FAIL %s wdata beat%0d: got %h required %h", name, beat, pmem_wdata, line[32*beat +: 32]);
            end
          end else begin
            d = use_fix ? fix[32*beat +: 32] : $urandom;
            got_line[32*beat +: 32] = d;
            pmem_rdata = d;
          end
          beat++;
        end else begin
          stalls++;
          pmem_rdata = $urandom;
        end
        pmem_resp = r;
        if (scramble && c == 2) begin
          l2_address = 16'hFFF0;
          l2_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no l2_resp within 200 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    rst = 1; l2_read = 0; l2_write = 0; l2_address = 16'h5A5A; l2_wdata = '1;
    pmem_rdata = '0; pmem_resp = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (l2_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: resp=%b rd=%b wr=%b required 0 0 0", l2_resp, pmem_read, pmem_write);
    end
    checks++;
    if (l2_rdata !== 128'h0 || pmem_address !== 16'h0 || pmem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0 0 0", l2_rdata, pmem_address, pmem_wdata);
    end
    rst = 0;
    exp_rdata = '0;
  endtask

  task automatic test_read_fixed();
    run_txn(0, 1, 16'h1234, '0, 1, 8'hFF, 1,
            128'h44444444_33333333_22222222_11111111, 0, "read_fixed");
    checks++;
    if (l2_rdata !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL read_fixed_line: got %h required 44444444333333332222222211111111", l2_rdata);
    end
  endtask

  task automatic test_write_stall();
    run_txn(1, 0, 16'h2008, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1, 8'b1111_1101,
            0, '0, 0, "write_stall");
  endtask

  task automatic test_both_high();
    run_txn(1, 1, 16'h4000, {$urandom, $urandom, $urandom, $urandom}, 0, 8'h0, 0, '0, 0, "both_high");
  endtask

  task automatic test_back_to_back();
    run_txn(1, 0, 16'h1000, {$urandom, $urandom, $urandom, $urandom}, 0, 8'h0, 0, '0, 0, "b2b_write");
    run_txn(0, 1, 16'h2000, '0, 0, 8'h0, 0, '0, 0, "b2b_read");
  endtask

  task automatic test_midreq_change();
    run_txn(0, 1, 16'h0010, '0, 1, 8'b1111_1011, 0, '0, 1, "midreq_read");
    run_txn(1, 0, 16'h0020, {$urandom, $urandom, $urandom, $urandom}, 1, 8'b1110_1111, 0, '0, 1, "midreq_write");
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    l2_read = 1; l2_write = 0; l2_address = 16'h3450; pmem_resp = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      pmem_resp = 1; pmem_rdata = $urandom;
    end
    @(negedge clk);
    pmem_resp = 1; pmem_rdata = $urandom;
    rst = 1; l2_read = 0;
    @(negedge clk);
    rst = 0; pmem_resp = 0;
    exp_rdata = '0;
    checks++;
    if (pmem_read !== 1'b0 || l2_resp !== 1'b0 || l2_rdata !== 128'h0 || pmem_address !== 16'h0) begin
      errors++;
      $display("FAIL reset_midread: rd=%b resp=%b rdata=%h addr=%h required 0 0 0 0",
               pmem_read, l2_resp, l2_rdata, pmem_address);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (l2_resp !== 1'b0 || pmem_read !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_resp cyc%0d: resp=%b rd=%b required 0 0", c, l2_resp, pmem_read);
      end
    end
    run_txn(0, 1, 16'h3450, '0, 0, 8'h0, 0, '0, 0, "after_reset_read");
  endtask

  task automatic test_random();
    bit wr, rd;
    for (int i = 0; i < 24; i++) begin
      wr = $urandom_range(0, 1);
      rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
      run_txn(wr, rd, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0, 8'h0, 0, '0,
              bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_fixed();
    test_write_stall();
    test_both_high();
    test_back_to_back();
    test_midreq_change();
    test_reset_midread();
    test_random();
    @(negedge clk);
    l2_read = 0; l2_write = 0; pmem_resp = 0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
